// File: rtl/gelato_inst_buffer.sv
// Multi-warp instruction buffer between decode and issue.
// One FIFO per warp, round-robin single issue port, per-warp flush.
//
// Ports:
//   clk, rst_n      clock, async active-low reset
//   enq_valid/ready decode handshake; target warp = enq_inst.warp_num
//   enq_inst        instruction to enqueue
//   issue_eligible  per-warp issue permission from scoreboard
//   issue_valid/ready issue handshake
//   issue_inst      head of the granted warp's queue
//   issue_warp      granted warp index
//   flush           per-warp queue clear
//   full, empty     per-warp occupancy flags (from registered counts)

package gelato_pkg;
    typedef logic [2:0] warp_num_t;

    typedef struct packed {
        warp_num_t   warp_num;
        logic [31:0] pc;
        logic [31:0] bits;
    } inst_t;
endpackage

module gelato_inst_buffer
    import gelato_pkg::*;
#(
    parameter  int NUM_WARPS = 4,
    parameter  int DEPTH     = 4,
    localparam int CNT_W     = $clog2(DEPTH + 1),
    localparam int WID_W     = $clog2(NUM_WARPS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enq_valid,
    input  inst_t                enq_inst,
    output logic                 enq_ready,
    input  logic [NUM_WARPS-1:0] issue_eligible,
    output logic                 issue_valid,
    output inst_t                issue_inst,
    output logic [WID_W-1:0]     issue_warp,
    input  logic                 issue_ready,
    input  logic [NUM_WARPS-1:0] flush,
    output logic [NUM_WARPS-1:0] full,
    output logic [NUM_WARPS-1:0] empty
);

    localparam int PTR_W = $clog2(DEPTH);

    typedef logic [PTR_W-1:0] ptr_t;

    inst_t            mem    [NUM_WARPS][DEPTH];
    logic [CNT_W-1:0] count  [NUM_WARPS];
    ptr_t             rd_ptr [NUM_WARPS];
    ptr_t             wr_ptr [NUM_WARPS];

    logic [WID_W-1:0]     rr_ptr;
    logic [WID_W-1:0]     grant;
    logic [WID_W-1:0]     enq_warp;
    logic                 in_range;
    logic                 enq_fire;
    logic                 issue_fire;
    logic [NUM_WARPS-1:0] cand;
    logic [NUM_WARPS-1:0] push;
    logic [NUM_WARPS-1:0] pop;

    function automatic ptr_t ptr_next(input ptr_t p);
        return (p == ptr_t'(DEPTH - 1)) ? '0 : p + ptr_t'(1);
    endfunction

    assign enq_warp = enq_inst.warp_num[WID_W-1:0];
    assign in_range = int'(enq_inst.warp_num) < NUM_WARPS;

    // No bypass: a pop in the same cycle never frees a slot for enqueue.
    assign enq_ready = in_range && !full[enq_warp] && !flush[enq_warp];
    assign enq_fire  = enq_valid && enq_ready;

    for (genvar w = 0; w < NUM_WARPS; w++) begin : g_warp
        assign full[w]  = (count[w] == CNT_W'(DEPTH));
        assign empty[w] = (count[w] == '0);
        assign cand[w]  = !empty[w] && issue_eligible[w] && !flush[w];
        assign push[w]  = enq_fire && (enq_warp == WID_W'(w));
        assign pop[w]   = issue_fire && (grant == WID_W'(w));
    end

    // Round-robin scan starting at rr_ptr.
    always_comb begin
        int idx;
        logic found;
        idx   = 0;
        found = 1'b0;
        grant = '0;
        for (int i = 0; i < NUM_WARPS; i++) begin
            idx = (int'(rr_ptr) + i) % NUM_WARPS;
            if (!found && cand[idx]) begin
                found = 1'b1;
                grant = WID_W'(idx);
            end
        end
    end

    assign issue_valid = |cand;
    assign issue_warp  = grant;
    assign issue_inst  = mem[grant][rd_ptr[grant]];
    assign issue_fire  = issue_valid && issue_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
            for (int w = 0; w < NUM_WARPS; w++) begin
                count[w]  <= '0;
                rd_ptr[w] <= '0;
                wr_ptr[w] <= '0;
            end
        end else begin
            if (issue_fire) begin
                rr_ptr <= (grant == WID_W'(NUM_WARPS - 1))
                        ? '0 : grant + WID_W'(1);
            end
            for (int w = 0; w < NUM_WARPS; w++) begin
                if (flush[w]) begin
                    count[w]  <= '0;
                    rd_ptr[w] <= '0;
                    wr_ptr[w] <= '0;
                end else begin
                    if (push[w]) wr_ptr[w] <= ptr_next(wr_ptr[w]);
                    if (pop[w])  rd_ptr[w] <= ptr_next(rd_ptr[w]);
                    count[w] <= count[w] + CNT_W'(push[w])
                                         - CNT_W'(pop[w]);
                end
            end
        end
    end

    // Storage carries no reset; validity is tracked by count.
    always_ff @(posedge clk) begin
        if (enq_fire) mem[enq_warp][wr_ptr[enq_warp]] <= enq_inst;
    end

    a_enq_range: assert property (
        @(posedge clk) disable iff (!rst_n) enq_valid |-> in_range);
    a_no_push_full: assert property (
        @(posedge clk) disable iff (!rst_n) !(enq_fire && full[enq_warp]));
    a_no_pop_empty: assert property (
        @(posedge clk) disable iff (!rst_n) !(issue_fire && empty[grant]));

endmodule

// File: doc/gelato_inst_buffer.md
Name: gelato_inst_buffer

Overview:
Multi-warp instruction buffer between decode and issue. It holds one FIFO per warp, each DEPTH entries of inst_t, generalising the single-entry inst_buffer_entry_t into parametrised per-warp queues. A single issue port selects one eligible warp per cycle by round-robin. Per-warp flush supports branch redirect and split-table reconvergence.

Parameters:
NUM_WARPS, 4, number of warp queues; >=2; must fit in warp_num_t.
DEPTH, 4, entries per warp queue; >=2; need not be a power of 2.
CNT_W, $clog2(DEPTH+1), width of each occupancy counter (derived, not overridable).
WID_W, $clog2(NUM_WARPS), width of issue_warp (derived).

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst_n  in  1  asynchronous active-low reset.
enq_valid  in  1  decode presents an instruction.
enq_inst  in  inst_t  instruction; its target queue is enq_inst.warp_num.
enq_ready  out  1  target queue accepts the instruction this cycle.
issue_eligible  in  NUM_WARPS  scoreboard/dispatch permits warp w to issue.
issue_valid  out  1  issue_inst is valid.
issue_inst  out  inst_t  head of the granted warp's queue.
issue_warp  out  WID_W  index of the granted warp.
issue_ready  in  1  downstream consumes issue_inst.
flush  in  NUM_WARPS  clear warp w's queue.
full  out  NUM_WARPS  count[w]==DEPTH.
empty  out  NUM_WARPS  count[w]==0.

Behaviour:
- Reset (rst_n low, async): all counts, rd/wr pointers and the round-robin pointer go to 0; issue_valid=0; full=0; empty=all ones. Storage array is not reset. issue_inst and issue_warp are don't-care while issue_valid=0.
- Per warp state: wr_ptr, rd_ptr (0..DEPTH-1, wrap DEPTH-1 -> 0), count (CNT_W bits).
- Enqueue:
  - enq_ready = (warp_num < NUM_WARPS) && !full[warp_num] && !flush[warp_num]. This is combinational from registered count plus the inputs.
  - There is no same-cycle bypass: when issue pops a full queue in the same cycle, enq_ready stays 0.
  - On enq_valid && enq_ready: write at wr_ptr, advance wr_ptr, count+1.
  - The entry becomes visible to issue the next cycle (1-cycle latency minimum through the buffer).
  - An out-of-range warp_num gives enq_ready=0 and fires a simulation assertion.
- Issue arbitration (combinational):
  - cand[w] = !empty[w] && issue_eligible[w] && !flush[w].
  - Grant the first w with cand[w] set, scanning rr_ptr, rr_ptr+1, ... modulo NUM_WARPS.
  - issue_valid = |cand. issue_inst = queue[g][rd_ptr[g]]. issue_warp = g.
  - On issue_valid && issue_ready: advance rd_ptr[g], count[g]-1, and rr_ptr <= (g+1) mod NUM_WARPS.
  - Without a handshake, rr_ptr holds and the grant stays stable while inputs are stable.
  - issue_valid may drop without a handshake when eligibility or flush changes; consumers must not depend on valid persistence.
- Simultaneous enqueue and issue on the same warp: count unchanged, both pointers advance.
- Flush[w]:
  - Next cycle, count[w]=0 and rd_ptr[w]=wr_ptr[w]=0.
  - Any enqueue to w in the same cycle is refused (enq_ready=0).
  - w is excluded from the grant that cycle.
  - Other warps are unaffected. Multiple flush bits may be set at once.
- Counter bounds: count never exceeds DEPTH and never underflows. Assertions check that no push occurs when full and no pop occurs when empty.
- full/empty are decoded from registered counts (registered-equivalent, with no input-to-output combinational path).
- Reset asserted mid-operation discards all queued instructions immediately. Outputs reach reset values asynchronously, without waiting for a clock edge.

Test Plan:
- Reset then single enqueue (warp 2, pc=0x100), all eligible, issue_ready=1 -> issue_valid=0 in the enqueue cycle; next cycle issue_valid=1, issue_warp=2, issue_inst.pc=0x100; empty[2]=1 after the handshake.
- Fill warp 0 with 4 instructions (DEPTH=4), issue_ready=0 -> full[0]=1 and enq_ready=0 for a 5th warp-0 instruction; a warp-1 enqueue is still accepted. Then drain with issue_ready=1 -> pcs issue in FIFO order across rd_ptr wrap.
- Warps 0..3 each hold 2 entries, all eligible, issue_ready=1 -> issue_warp sequence 0,1,2,3,0,1,2,3. Then with issue_eligible=4'b1010 -> only warps 1 and 3 are granted, alternating.
- Warp 1 holds 3 entries, flush[1] pulsed together with enq_valid to warp 1 -> enq_ready=0; next cycle empty[1]=1 and issue_valid=0 when no other warp holds entries; a later enqueue to warp 1 issues with the new pc only.
- Warp 3 full (4 entries) with issue granted to warp 3 and enq_valid to warp 3 in the same cycle -> enq_ready=0, count becomes 3. Next cycle, an enqueue plus issue on warp 3 -> count stays 3.
- Assert rst_n=0 asynchronously mid-stream with entries in every queue -> issue_valid=0 and empty=4'b1111 without a clock edge; after release, the first grant starts at warp 0.
